xillybus_stream_arbiter: RTL
============================

XILLYBUS_STREAM_ARBITER -- requirements
Module: xillybus_stream_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of host-to-FPGA write channels, range 2..8.
REQ-002 SHALL have parameter DW, default 32: data width per channel.
REQ-003 SHALL have parameter DEPTH, default 16: words per channel FIFO, power of two, minimum 4.
REQ-004 SHALL define CW = max(1, clog2(NCH)) and AW = clog2(DEPTH) as local parameters.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 bus_clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 bus_rst_n  in  1  asynchronous active-low reset.
REQ-008 user_w_wren  in  NCH  per-channel write strobe.
REQ-009 user_w_data  in  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW].
REQ-010 user_w_full  out  NCH  per-channel FIFO full.
REQ-011 user_w_open  in  NCH  per-channel stream-open flag.
REQ-012 out_valid  out  1  output word valid.
REQ-013 out_ready  in  1  downstream accepts the word.
REQ-014 out_data  out  DW  output word.
REQ-015 out_ch  out  CW  source channel of out_data.
REQ-016 out_last  out  1  final word of a closed stream.
REQ-017 ovf  out  NCH  sticky per-channel overflow flag.

Function
REQ-018 Each channel SHALL have an independent FIFO of DEPTH words with an AW+1-bit occupancy count.
REQ-019 user_w_full[i] SHALL be high exactly when count[i] == DEPTH; the output is combinational from the count register.
REQ-020 A write SHALL be accepted when wren[i]=1, open[i]=1 and full[i]=0.
REQ-021 A write with wren[i]=1 and full[i]=1 SHALL be discarded and SHALL set ovf[i], even if a pop occurs on that channel in the same cycle.
REQ-022 A write with wren[i]=1 and open[i]=0 SHALL be discarded without setting ovf[i].
REQ-023 ovf[i] SHALL clear on the rising edge of open[i] (0 -> 1, registered compare) or on reset.
REQ-024 The output register SHALL load when out_valid=0 or (out_valid=1 and out_ready=1); otherwise out_valid, out_data, out_ch and out_last SHALL hold.
REQ-025 On load, the arbiter SHALL grant the first non-empty channel in round-robin order, starting at rr_ptr; it SHALL pop one word from that FIFO and set out_valid=1.
REQ-026 After each grant to channel g, rr_ptr SHALL become (g+1) mod NCH; with no grant, rr_ptr SHALL hold.
REQ-027 If no channel is non-empty at a load opportunity, out_valid SHALL go to 0.
REQ-028 Latency SHALL be: a word accepted at edge E0, into an empty block with out_ready=1, appears with out_valid=1 after edge E1.
REQ-029 A simultaneous push and pop on the same FIFO SHALL leave count unchanged, and both operations SHALL take effect.
REQ-030 Each channel SHALL have a closing flag, set on the falling edge of open[i] (1 -> 0) when count[i] > 0.
REQ-031 While closing[i]=1, the pop that empties FIFO i SHALL load out_last=1; that pop SHALL also clear closing[i].
REQ-032 Every other load SHALL set out_last=0.
REQ-033 If open[i] rises while closing[i]=1, closing[i] SHALL clear, no out_last SHALL be emitted for the earlier stream, and buffered data SHALL be retained.
REQ-034 A falling edge of open[i] with count[i]=0 SHALL produce no output.
REQ-035 Pointer arithmetic SHALL wrap modulo DEPTH, and the FIFO storage SHALL be inferable as distributed RAM.

Reset
REQ-036 While bus_rst_n=0, the following SHALL be forced to 0 asynchronously: out_valid, out_data, out_ch, out_last, ovf, all counts, all pointers, rr_ptr, closing flags and the registered open history.
REQ-037 Resulting outputs under reset SHALL be user_w_full=0 and out_valid=0.
REQ-038 Reset during operation SHALL discard all buffered data.
REQ-039 The first accepted write after bus_rst_n deasserts SHALL behave per REQ-028.

Verification
REQ-040 Round-robin: NCH=2, out_ready=1, ch0 and ch1 each hold 3 words -> out_ch sequence 0,1,0,1,0,1 with data in FIFO order.
REQ-041 Full/overflow: DEPTH=16, out_ready=0, 17 writes on ch0 -> full[0]=1 after the 16th; 17th word lost; ovf[0]=1.
REQ-042 Overflow clear: after the REQ-041 case, open[0] 1 -> 0 -> 1 -> ovf[0]=0.
REQ-043 Close: ch1 holds A,B; open[1] falls -> B emitted with out_last=1; A emitted with out_last=0; closing flag cleared.
REQ-044 Backpressure: out_valid=1, out_ready=0 for 5 cycles, concurrent writes -> outputs stable; no word lost or duplicated after out_ready=1.
REQ-045 Reset mid-burst: bus_rst_n pulsed low with 8 words buffered -> out_valid=0 immediately; the next single write appears after one edge.

Source files
------------

// File: rtl/xillybus_stream_arbiter.sv
// Round-robin merge of NCH host-to-FPGA write streams into one valid/ready output.
// Each channel has its own small FIFO; end-of-stream is flagged on the last buffered word.
module xillybus_stream_arbiter #(
   parameter int NCH   = 2,
   parameter int DW    = 32,
   parameter int DEPTH = 16
) (
   input  logic                        bus_clk,
   input  logic                        bus_rst_n,
   input  logic [NCH-1:0]              user_w_wren,
   input  logic [NCH*DW-1:0]           user_w_data,
   output logic [NCH-1:0]              user_w_full,
   input  logic [NCH-1:0]              user_w_open,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DW-1:0]               out_data,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
   output logic                        out_last,
   output logic [NCH-1:0]              ovf
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0]  mem [NCH][DEPTH];
   logic [AW-1:0]  wr_ptr [NCH];
   logic [AW-1:0]  rd_ptr [NCH];
   logic [AW:0]    count [NCH];
   logic [NCH-1:0] closing;
   logic [NCH-1:0] open_q;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   logic [NCH-1:0] ovf_hit;
   logic [CW-1:0]  rr_ptr;
   logic [CW-1:0]  gnt;
   logic           gnt_vld;
   logic           load;
   logic           last_nxt;
   int             j;

   assign rise = user_w_open & ~open_q;
   assign fall = ~user_w_open & open_q;
   assign load = ~out_valid | out_ready;

   always_comb begin
      user_w_full = '0;
      push        = '0;
      ovf_hit     = '0;
      for (int i = 0; i < NCH; i++) begin
         user_w_full[i] = (count[i] == (AW+1)'(DEPTH));
         push[i]        = user_w_wren[i] & user_w_open[i] & ~user_w_full[i];
         ovf_hit[i]     = user_w_wren[i] & user_w_open[i] & user_w_full[i];
      end
   end

   // First non-empty channel at or after rr_ptr, wrapping.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      j       = 0;
      for (int k = 0; k < NCH; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NCH) j = j - NCH;
         if (!gnt_vld && count[j] != '0) begin
            gnt_vld = 1'b1;
            gnt     = CW'(j);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++)
         pop[i] = load & gnt_vld & (gnt == CW'(i));
   end

   // A fall seen on the same edge as the emptying pop still marks that word as last.
   assign last_nxt = ((closing[gnt] & ~rise[gnt]) | fall[gnt])
                     & (count[gnt] == (AW+1)'(1)) & ~push[gnt];

   always_ff @(posedge bus_clk) begin
      for (int i = 0; i < NCH; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= user_w_data[i*DW +: DW];
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         closing <= '0;
         open_q  <= '0;
         ovf     <= '0;
      end else begin
         open_q <= user_w_open;
         for (int i = 0; i < NCH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
            else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;

            if (ovf_hit[i])   ovf[i] <= 1'b1;
            else if (rise[i]) ovf[i] <= 1'b0;

            if (rise[i])
               closing[i] <= 1'b0;
            else if (pop[i] && count[i] == (AW+1)'(1) && !push[i])
               closing[i] <= 1'b0;
            else if (fall[i] && count[i] != '0)
               closing[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         rr_ptr    <= '0;
      end else if (load) begin
         out_valid <= gnt_vld;
         if (gnt_vld) begin
            out_data <= mem[gnt][rd_ptr[gnt]];
            out_ch   <= gnt;
            out_last <= last_nxt;
            if (int'(gnt) == NCH - 1) rr_ptr <= '0;
            else                      rr_ptr <= gnt + 1'b1;
         end else begin
            out_last <= 1'b0;
         end
      end
   end

endmodule
